fp_mat_add_seq: RTL and testbench
=================================

Name: fp_mat_add_seq

Overview:
- Initiator-side sequencer for the single-precision adder handshake (load / result_ready / result_ack).
- Accepts two WIDTH x WIDTH float32 matrices on a load/ready interface.
- Streams element pairs one at a time into one shared adder instance and buffers the sums.
- Presents the full result matrix with a ready flag; used as the low-area alternative to the fully parallel matrix adder.

Parameters:
- WIDTH, 2, matrix dimension; N = WIDTH*WIDTH elements.
- DW, 32, element width (IEEE-754 single).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- load  in  1  start request, level-sampled in IDLE only.
- A  in  DW*N  operand matrix, flattened; element i at bits [DW*i+DW-1 : DW*i], row-major.
- B  in  DW*N  operand matrix, same packing as A.
- ready  out  1  result matrix valid.
- result  out  DW*N  sum matrix, same packing as A.
- add_load  out  1  one-cycle start pulse to the adder.
- add_a  out  DW  adder Number1.
- add_b  out  DW  adder Number2.
- add_result  in  DW  adder Result.
- add_result_ready  in  1  adder result valid.
- add_result_ack  out  1  acknowledge to the adder.

Behaviour:
- Reset, sampled on the clk edge:
  - state=IDLE, idx=0.
  - ready=0, result=0, add_load=0, add_a=0, add_b=0, add_result_ack=0.
  - Internal operand and result buffers cleared.
  - Reset mid-operation aborts the operation, discards captured operands, and returns to IDLE. The adder shares the same reset.
- States: IDLE, ISSUE, WAIT, ACK, DONE.
- IDLE:
  - On load=1: capture A and B into internal registers, idx=0, ready<=0, go to ISSUE.
  - Otherwise hold; ready and result stay unchanged.
- ISSUE:
  - add_a<=A_cap[idx], add_b<=B_cap[idx], add_load<=1 for exactly one cycle, go to WAIT.
  - add_a and add_b hold their values until the next ISSUE.
- WAIT:
  - add_result_ready is sampled starting the cycle after add_load.
  - When it is 1: buf[idx]<=add_result, add_result_ack<=1, go to ACK.
  - No timeout; waits indefinitely.
- ACK (four-phase handshake):
  - Hold add_result_ack=1 until add_result_ready is sampled 0, then add_result_ack<=0.
  - If idx==N-1, go to DONE; else idx<=idx+1 and go to ISSUE.
- DONE:
  - result<=buf (all N elements in one cycle), ready<=1, go to IDLE.
- Output stability:
  - result changes only in DONE or on reset, never element-by-element while busy.
  - ready stays 1 until the cycle after the next accepted load.
- load handling:
  - load while busy (not IDLE) is ignored; it is not queued.
  - load held high continuously restarts immediately from IDLE. ready is then high for exactly 1 cycle per operation, and result updates each operation.
- A and B may change after the capture cycle without affecting the operation in progress.
- Latency: with adder latency L (add_load to add_result_ready) and ack drop after 1 cycle, one element costs L+3 cycles. Load to ready = 1 + N*(L+3) + 1 cycles.
- idx width is clog2(N), minimum 1. For WIDTH=1, N=1 and the first element goes straight to DONE.
- No arithmetic in this block; the adder alone handles floating-point semantics.

Test Plan:
- Reset: assert reset 2 cycles mid-operation (during WAIT of element 1) -> next cycle ready=0, result=0, add_load=0, add_result_ack=0; state IDLE; no further add_load pulses until load.
- Basic: WIDTH=2, all A and B elements = 0x40BAE148, adder model with L=3, load pulse -> exactly 4 add_load pulses, each followed by an ack handshake. ready rises 1+4*6+1 = 26 cycles after load; every result element = 0x413AE148.
- Mixed values: A={0x3F800000, 0x40000000, 0xBF800000, 0x00000000}, B={0x3F800000, 0x3F800000, 0x3F800000, 0x40400000} -> result={0x40000000, 0x40400000, 0x00000000, 0x40400000}. add_a and add_b are presented in index order 0..3.
- Handshake stretch: adder model holds add_result_ready high 5 cycles after ack -> add_result_ack held high the whole time; no new add_load until add_result_ready is sampled 0; results still correct.
- Busy load and operand change: pulse load again and change A to all-zero during element 2 -> ignored; result matches the originally captured operands; ready asserts once.
- Continuous load: hold load=1 for 3 operations -> ready is high exactly 1 cycle per operation; result is stable between DONE cycles; 12 add_load pulses total.

Source files
------------

// File: rtl/fp_mat_add_seq.sv
// fp_mat_add_seq: streams WIDTH x WIDTH float32 element pairs through one
// shared adder over a four-phase load / result_ready / result_ack handshake.
module fp_mat_add_seq #(
    parameter int WIDTH = 2,
    parameter int DW    = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load,
    input  logic [DW*WIDTH*WIDTH-1:0] A,
    input  logic [DW*WIDTH*WIDTH-1:0] B,
    output logic                      ready,
    output logic [DW*WIDTH*WIDTH-1:0] result,
    output logic                      add_load,
    output logic [DW-1:0]             add_a,
    output logic [DW-1:0]             add_b,
    input  logic [DW-1:0]             add_result,
    input  logic                      add_result_ready,
    output logic                      add_result_ack
);

    localparam int N  = WIDTH * WIDTH;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef logic [N-1:0][DW-1:0] mat_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        ACK,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    mat_t          a_cap_q, a_cap_d;
    mat_t          b_cap_q, b_cap_d;
    mat_t          buf_q, buf_d;
    mat_t          result_q, result_d;
    logic          ready_q, ready_d;
    logic          add_load_q, add_load_d;
    logic [DW-1:0] add_a_q, add_a_d;
    logic [DW-1:0] add_b_q, add_b_d;
    logic          ack_q, ack_d;
    logic          last;

    assign last = (idx_q == IW'(N - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            a_cap_q    <= '0;
            b_cap_q    <= '0;
            buf_q      <= '0;
            result_q   <= '0;
            ready_q    <= 1'b0;
            add_load_q <= 1'b0;
            add_a_q    <= '0;
            add_b_q    <= '0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            a_cap_q    <= a_cap_d;
            b_cap_q    <= b_cap_d;
            buf_q      <= buf_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
            add_load_q <= add_load_d;
            add_a_q    <= add_a_d;
            add_b_q    <= add_b_d;
            ack_q      <= ack_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (load) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (add_result_ready) state_d = ACK;
            ACK: begin
                if (!add_result_ready) begin
                    state_d = last ? DONE : ISSUE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // add_load defaults low so it only ever pulses for the ISSUE cycle
    always_comb begin
        idx_d      = idx_q;
        a_cap_d    = a_cap_q;
        b_cap_d    = b_cap_q;
        buf_d      = buf_q;
        result_d   = result_q;
        ready_d    = ready_q;
        add_load_d = 1'b0;
        add_a_d    = add_a_q;
        add_b_d    = add_b_q;
        ack_d      = ack_q;
        unique case (state_q)
            IDLE: begin
                if (load) begin
                    a_cap_d = A;
                    b_cap_d = B;
                    idx_d   = '0;
                    ready_d = 1'b0;
                end
            end
            ISSUE: begin
                add_a_d    = a_cap_q[idx_q];
                add_b_d    = b_cap_q[idx_q];
                add_load_d = 1'b1;
            end
            WAIT: begin
                if (add_result_ready) begin
                    buf_d[idx_q] = add_result;
                    ack_d        = 1'b1;
                end
            end
            ACK: begin
                if (!add_result_ready) begin
                    ack_d = 1'b0;
                    if (!last) idx_d = idx_q + IW'(1);
                end
            end
            DONE: begin
                result_d = buf_q;
                ready_d  = 1'b1;
            end
            default: ;
        endcase
    end

    assign ready          = ready_q;
    assign result         = result_q;
    assign add_load       = add_load_q;
    assign add_a          = add_a_q;
    assign add_b          = add_b_q;
    assign add_result_ack = ack_q;

endmodule

// File: tb/tb_fp_mat_add_seq.sv
// tb_fp_mat_add_seq: directed vectors for the sequential matrix adder,
// driven against a behavioural four-phase adder responder.
module tb_fp_mat_add_seq;

    localparam int LAT = 3;

    logic               clk = 1'b0;
    logic               reset;
    logic               load;
    logic [3:0][31:0]   A, B;
    logic               ready;
    logic [3:0][31:0]   result;
    logic               add_load;
    logic [31:0]        add_a, add_b;
    logic [31:0]        add_result;
    logic               add_result_ready;
    logic               add_result_ack;

    int errors = 0;
    int checks = 0;
    int hold   = 0;

    fp_mat_add_seq #(.WIDTH(2), .DW(32)) dut (
        .clk              (clk),
        .reset            (reset),
        .load             (load),
        .A                (A),
        .B                (B),
        .ready            (ready),
        .result           (result),
        .add_load         (add_load),
        .add_a            (add_a),
        .add_b            (add_b),
        .add_result       (add_result),
        .add_result_ready (add_result_ready),
        .add_result_ack   (add_result_ack)
    );

    always #5 clk = ~clk;

    function automatic bit pr(input logic [31:0] x, y, p, q);
        return (x == p && y == q) || (x == q && y == p);
    endfunction

    // hand-computed float32 sums for the operand pairs used below
    function automatic logic [31:0] fadd(input logic [31:0] x, y);
        if (x == 32'h0) return y;
        if (y == 32'h0) return x;
        if (pr(x, y, 32'h40BAE148, 32'h40BAE148)) return 32'h413AE148;
        if (pr(x, y, 32'h3F800000, 32'h3F800000)) return 32'h40000000;
        if (pr(x, y, 32'h40000000, 32'h3F800000)) return 32'h40400000;
        if (pr(x, y, 32'hBF800000, 32'h3F800000)) return 32'h00000000;
        return 32'hDEADBEEF;
    endfunction

    logic        pend;
    int          cnt, hcnt;
    logic [31:0] ra, rb;

    always @(posedge clk) begin
        if (reset) begin
            add_result_ready <= 1'b0;
            add_result       <= '0;
            pend             <= 1'b0;
            cnt              <= 0;
            hcnt             <= 0;
        end else begin
            if (add_load) begin
                pend <= 1'b1;
                cnt  <= LAT - 2;
                ra   <= add_a;
                rb   <= add_b;
            end else if (pend) begin
                if (cnt <= 1) begin
                    add_result_ready <= 1'b1;
                    add_result       <= fadd(ra, rb);
                    pend             <= 1'b0;
                    hcnt             <= hold;
                end else begin
                    cnt <= cnt - 1;
                end
            end
            if (add_result_ready && add_result_ack) begin
                if (hcnt == 0) add_result_ready <= 1'b0;
                else hcnt <= hcnt - 1;
            end
        end
    end

    int          nload = 0, nrise = 0, viol = 0;
    logic [31:0] la [256];
    logic [31:0] lb [256];
    logic        p_ack = 0, p_rdy = 0, p_ready = 0, p_rst = 0, p_ld = 0;
    logic [3:0][31:0] p_res = '0;

    always @(negedge clk) begin
        if (add_load) begin
            la[nload % 256] <= add_a;
            lb[nload % 256] <= add_b;
            nload           <= nload + 1;
        end
        if ((add_load && (add_result_ready || add_result_ack)) ||
            (add_load && p_ld) ||
            (p_ack && !add_result_ack && p_rdy) ||
            (result != p_res && !(ready && !p_ready) && !p_rst && !reset))
            viol <= viol + 1;
        if (ready && !p_ready) nrise <= nrise + 1;
        p_ack   <= add_result_ack;
        p_rdy   <= add_result_ready;
        p_ready <= ready;
        p_rst   <= reset;
        p_ld    <= add_load;
        p_res   <= result;
    end

    task automatic chk(input string n, input logic [31:0] act, exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0][31:0] a;
        logic [3:0][31:0] b;
        logic [3:0][31:0] e;
        int               hold;
        int               lat;
    } vec_t;

    vec_t v [3];

    task automatic run_vec(input int k);
        int base, vb, cyc;
        base = nload;
        vb   = viol;
        hold = v[k].hold;
        @(negedge clk);
        A = v[k].a; B = v[k].b; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        chk($sformatf("v%0d ready_clr", k), 32'(ready), 32'd0);
        cyc = 1;
        while (!ready && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        chk($sformatf("v%0d latency", k), cyc, v[k].lat);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("v%0d res[%0d]", k, i), result[i], v[k].e[i]);
            chk($sformatf("v%0d add_a[%0d]", k, i),
                la[(base + i) % 256], v[k].a[i]);
            chk($sformatf("v%0d add_b[%0d]", k, i),
                lb[(base + i) % 256], v[k].b[i]);
        end
        repeat (3) @(negedge clk);
        chk($sformatf("v%0d ready_hold", k), 32'(ready), 32'd1);
        chk($sformatf("v%0d pulses", k), nload - base, 4);
        chk($sformatf("v%0d viol", k), viol - vb, 0);
    endtask

    initial begin
        int base, rbase, vb, t;

        v[0].a    = {4{32'h40BAE148}};
        v[0].b    = {4{32'h40BAE148}};
        v[0].e    = {4{32'h413AE148}};
        v[0].hold = 0;
        v[0].lat  = 26;
        v[1].a    = {32'h00000000, 32'hBF800000, 32'h40000000, 32'h3F800000};
        v[1].b    = {32'h40400000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
        v[1].e    = {32'h40400000, 32'h00000000, 32'h40400000, 32'h40000000};
        v[1].hold = 0;
        v[1].lat  = 26;
        v[2].a    = v[1].b;
        v[2].b    = v[1].a;
        v[2].e    = v[1].e;
        v[2].hold = 5;
        v[2].lat  = 46;

        reset = 1'b1; load = 1'b0; A = '0; B = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst ready", 32'(ready), 32'd0);
        chk("rst result", result[0] | result[1] | result[2] | result[3], 32'd0);
        chk("rst add_load", 32'(add_load), 32'd0);
        chk("rst ack", 32'(add_result_ack), 32'd0);
        chk("rst add_a", add_a, 32'd0);

        for (int k = 0; k < 3; k++) run_vec(k);
        hold = 0;

        // load pulse and operand change while busy on element 2
        base = nload; rbase = nrise; vb = viol;
        @(negedge clk);
        A = v[0].a; B = v[0].b; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        t = 0;
        while (nload < base + 3 && t < 300) begin
            @(posedge clk);
            t++;
        end
        chk("busy reach_e2", 32'(nload - base), 32'd3);
        @(negedge clk);
        load = 1'b1; A = '0;
        @(negedge clk);
        load = 1'b0;
        t = 0;
        while (!ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        for (int i = 0; i < 4; i++)
            chk($sformatf("busy res[%0d]", i), result[i], v[0].e[i]);
        repeat (10) @(negedge clk);
        chk("busy rises", nrise - rbase, 1);
        chk("busy pulses", nload - base, 4);
        chk("busy viol", viol - vb, 0);

        // load held high for three back-to-back operations
        base = nload; rbase = nrise; vb = viol;
        @(negedge clk);
        A = v[1].a; B = v[1].b; load = 1'b1;
        for (int op = 0; op < 3; op++) begin
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!ready && t < 300);
            for (int i = 0; i < 4; i++)
                chk($sformatf("cont%0d res[%0d]", op, i), result[i], v[1].e[i]);
            if (op < 2) begin
                @(negedge clk);
                chk($sformatf("cont%0d ready_pulse", op), 32'(ready), 32'd0);
            end else begin
                load = 1'b0;
            end
        end
        repeat (20) @(negedge clk);
        chk("cont pulses", nload - base, 12);
        chk("cont rises", nrise - rbase, 3);
        chk("cont viol", viol - vb, 0);

        // reset during WAIT of element 1
        base = nload;
        @(negedge clk);
        A = v[1].a; B = v[1].b; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        t = 0;
        while (nload < base + 2 && t < 300) begin
            @(posedge clk);
            t++;
        end
        chk("mid reach_e1", 32'(nload - base), 32'd2);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("mid ready", 32'(ready), 32'd0);
        chk("mid result", result[0] | result[1] | result[2] | result[3], 32'd0);
        chk("mid add_load", 32'(add_load), 32'd0);
        chk("mid ack", 32'(add_result_ack), 32'd0);
        repeat (40) @(negedge clk);
        chk("mid no_pulses", nload - base, 2);
        chk("mid idle_ready", 32'(ready), 32'd0);

        run_vec(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
